// File: rtl/core_mem_timer.sv
// Core-memory read/restore/write phase timer: READ, optional WAIT, WRITE.
// Optional feature: define CORE_MEM_TIMER_TMO_EN to enable the WAIT timeout.
module core_mem_timer #(
    parameter int READ_TICKS    = 60,
    parameter int STROBE_TICK   = 35,
    parameter int WRITE_TICKS   = 60,
    parameter int TIMEOUT_TICKS = 10000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic rd,
    input  logic wr,
    input  logic wr_rs,
    output logic busy,
    output logic read_l,
    output logic strobe,
    output logic rd_rs,
    output logic write_l,
    output logic done,
    output logic tmo
);

    localparam int MAX_RW = (READ_TICKS > WRITE_TICKS) ? READ_TICKS : WRITE_TICKS;
    localparam int MAX_T  = (MAX_RW > TIMEOUT_TICKS) ? MAX_RW : TIMEOUT_TICKS;
    localparam int CW     = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] R_END = CW'(READ_TICKS);
    localparam logic [CW-1:0] S_TCK = CW'(STROBE_TICK);
    localparam logic [CW-1:0] W_END = CW'(WRITE_TICKS);
`ifdef CORE_MEM_TIMER_TMO_EN
    localparam logic [CW-1:0] T_END = CW'(TIMEOUT_TICKS);
`endif

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        WRITE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rdl, rdl_n;
    logic          wrl, wrl_n;
    logic          tmo_hit;

    // WAIT expiry; a wr_rs on the same cycle wins and suppresses it
`ifdef CORE_MEM_TIMER_TMO_EN
    assign tmo_hit = (state == WAIT) && (cnt == T_END) && !wr_rs;
`else
    assign tmo_hit = 1'b0;
`endif
    assign tmo = tmo_hit;

    // Next-state and phase-counter logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rdl_n   = rdl;
        wrl_n   = wrl;
        unique case (state)
            IDLE: begin
                if (start && (rd || wr)) begin
                    state_n = READ;
                    cnt_n   = ONE;
                    rdl_n   = rd;
                    wrl_n   = wr;
                end
            end
            READ: begin
                if (cnt == R_END) begin
                    // destructive read: anything but RMW restores at once
                    state_n = (rdl && wrl) ? WAIT : WRITE;
                    cnt_n   = ONE;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            WAIT: begin
                if (wr_rs || tmo_hit) begin
                    state_n = WRITE;
                    cnt_n   = ONE;
                end else begin
`ifdef CORE_MEM_TIMER_TMO_EN
                    cnt_n = cnt + ONE;
`else
                    cnt_n = cnt;
`endif
                end
            end
            WRITE: begin
                if (cnt == W_END) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    rdl_n   = 1'b0;
                    wrl_n   = 1'b0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State registers and outputs registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rdl     <= 1'b0;
            wrl     <= 1'b0;
            busy    <= 1'b0;
            read_l  <= 1'b0;
            strobe  <= 1'b0;
            rd_rs   <= 1'b0;
            write_l <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rdl     <= rdl_n;
            wrl     <= wrl_n;
            busy    <= (state_n != IDLE);
            read_l  <= (state_n == READ);
            strobe  <= (state_n == READ) && (cnt_n == S_TCK) && rdl_n;
            rd_rs   <= (state_n == READ) && (cnt_n == R_END) && rdl_n;
            write_l <= (state_n == WRITE);
            done    <= (state_n == WRITE) && (cnt_n == W_END);
        end
    end

endmodule

// File: tb/tb_core_mem_timer.sv
// Directed bench for core_mem_timer with a per-cycle expected-vector scoreboard.
// Run with or without CORE_MEM_TIMER_TMO_EN; the timeline model follows the build.
module tb_core_mem_timer;

    localparam int TT = 20;
`ifdef CORE_MEM_TIMER_TMO_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, rd, wr, wr_rs;
    logic busy, read_l, strobe, rd_rs, write_l, done, tmo;

    int vectors = 0;
    int miscompares = 0;
    logic [6:0] sb_q[$];

    core_mem_timer #(
        .READ_TICKS(60),
        .STROBE_TICK(35),
        .WRITE_TICKS(60),
        .TIMEOUT_TICKS(TT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rd(rd),
        .wr(wr),
        .wr_rs(wr_rs),
        .busy(busy),
        .read_l(read_l),
        .strobe(strobe),
        .rd_rs(rd_rs),
        .write_l(write_l),
        .done(done),
        .tmo(tmo)
    );

    always #5 clk = ~clk;

    // last busy cycle of a transaction started at k=0
    function automatic int end_cycle(input bit r, input bit w, input int wrs);
        int we;
        if (r && w) begin
            we = wrs;
            if (TMO && wrs > 60 + TT) we = 60 + TT;
            return we + 60;
        end
        return 120;
    endfunction

    // {busy,read_l,strobe,rd_rs,write_l,done,tmo} at cycle k
    function automatic logic [6:0] model(input int k, input bit r, input bit w,
                                         input int wrs);
        int e;
        int ws;
        bit t;
        e  = end_cycle(r, w, wrs);
        ws = e - 59;
        t  = r && w && TMO && (wrs > 60 + TT) && (k == 60 + TT);
        return {k >= 1 && k <= e,
                k >= 1 && k <= 60,
                r && k == 35,
                r && k == 60,
                k >= ws && k <= e,
                k == e,
                t};
    endfunction

    function automatic logic [6:0] obs();
        return {busy, read_l, strobe, rd_rs, write_l, done, tmo};
    endfunction

    task automatic check(input string tag, input int k);
        logic [6:0] e;
        logic [6:0] o;
        e = sb_q.pop_front();
        o = obs();
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, o, e);
        end
    endtask

    // one transaction: start at k=0, wr_rs at k==wrs, optional noise/reset
    task automatic run(input string tag, input bit r, input bit w,
                       input int wrs, input int ncyc, input bit noise,
                       input int rst_at);
        int e;
        e = end_cycle(r, w, wrs);
        for (int k = 0; k <= ncyc; k++) begin
            start = (k == 0) || (noise && (k == 50 || k == e));
            rd    = (k == 0) ? r : 1'b1;
            wr    = (k == 0) ? w : 1'b1;
            wr_rs = (k == wrs) || (noise && k == 40);
            if (rst_at >= 0) begin
                if (k == rst_at) reset = 1'b1;
                if (k == rst_at + 3) reset = 1'b0;
            end
            if (rst_at >= 0 && k >= rst_at)
                sb_q.push_back(7'b0);
            else
                sb_q.push_back(model(k, r, w, wrs));
            #1;
            check(tag, k);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wr_rs = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        wr_rs = 1'b0;
        #2;
        sb_q.push_back(7'b0);
        check("reset", 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        // read-only
        run("rd_only", 1'b1, 1'b0, -1, 125, 1'b0, -1);
        // read-modify-write, wr_rs at 100
        run("rmw", 1'b1, 1'b1, 100, 165, 1'b0, -1);
        // write-only
        run("wr_only", 1'b0, 1'b1, -1, 125, 1'b0, -1);
        // ignored start/wr_rs, start on the done cycle
        run("ignored", 1'b1, 1'b0, -1, 130, 1'b1, -1);
        // wr_rs landing on the timeout cycle
        run("rmw_80", 1'b1, 1'b1, 60 + TT, 145, 1'b0, -1);
        // long wait: times out if enabled, else waits for wr_rs at 200
        run("long_wait", 1'b1, 1'b1, 200, 265, 1'b0, -1);
        // reset mid-read-restore, then replay
        run("reset_mid", 1'b1, 1'b0, -1, 80, 1'b0, 70);
        run("replay", 1'b1, 1'b0, -1, 125, 1'b0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
